// File: rtl/pwm_capture_scheduler.sv
// Round-robin PWM duty capture: one shared width counter scans NUM_CH synchronized inputs.
// Latency: 2-cycle input sync plus PERIOD measure cycles and 1 store cycle per channel.
// No backpressure: done pulses for one cycle and the duty table is read combinationally.
module pwm_capture_scheduler #(
  parameter int NUM_CH          = 4,
  parameter int PERIOD_WIDTH_NS = 100000,
  parameter int SYS_FREQ_MHZ    = 100,
  localparam int CW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] signals,
  input  logic              pri_req,
  input  logic [CW-1:0]     pri_ch,
  input  logic [CW-1:0]     rd_sel,
  output logic [9:0]        rd_duty,
  output logic              done,
  output logic [CW-1:0]     done_ch,
  output logic [9:0]        done_duty,
  output logic              busy
);

  localparam int PERIOD = PERIOD_WIDTH_NS * SYS_FREQ_MHZ / 1000;
  localparam int WW     = $clog2(PERIOD) + 1;
  localparam int PW     = WW + 10;

  typedef enum logic [1:0] {IDLE, MEASURE, STORE} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] sync1, sync2;
  logic              sel_signal;
  logic [WW-1:0]     cnt, width;
  logic [CW-1:0]     cur_ch, next_ch;
  logic [PW-1:0]     product;
  logic [9:0]        duty_calc;
  logic [9:0]        duty_q [NUM_CH];

  // Two-flop synchronizer on every raw PWM line; the extra latency is not compensated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= signals;
      sync2 <= sync1;
    end
  end

  assign sel_signal = sync2[cur_ch];

  // Duty scaling: width*1023/PERIOD truncated; a fully-high window yields exactly 1023.
  assign product   = PW'(width) * PW'(1023);
  assign duty_calc = 10'(product / PW'(PERIOD));

  // Next channel: in-range priority request wins, otherwise wrap-around rotation.
  always_comb begin
    if (cur_ch == CW'(NUM_CH - 1)) next_ch = '0;
    else                           next_ch = cur_ch + 1'b1;
    if (pri_req && (int'(pri_ch) < NUM_CH)) next_ch = pri_ch;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: disable aborts a measurement but never a store in progress.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = MEASURE;
      MEASURE: begin
        if (!enable)                        state_nxt = IDLE;
        else if (cnt == WW'(PERIOD - 1))    state_nxt = STORE;
      end
      STORE:   state_nxt = enable ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Measurement datapath: accumulate high samples, restart counters, advance channel on store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      width  <= '0;
      cur_ch <= '0;
    end else begin
      case (state)
        MEASURE: begin
          cnt   <= cnt + 1'b1;
          width <= width + WW'(sel_signal);
        end
        STORE: begin
          cnt    <= '0;
          width  <= '0;
          cur_ch <= next_ch;
        end
        default: begin
          cnt   <= '0;
          width <= '0;
        end
      endcase
    end
  end

  // Duty table: written at the end of the store cycle, so reads see the old value during it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else if (state == STORE) begin
      duty_q[cur_ch] <= duty_calc;
    end
  end

  // Combinational read port; out-of-range selects read as zero.
  always_comb begin
    rd_duty = '0;
    if (int'(rd_sel) < NUM_CH) rd_duty = duty_q[rd_sel];
  end

  // Output decode: done and its payload are only non-zero in the store cycle.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == STORE);
    done_ch   = '0;
    done_duty = '0;
    if (state == STORE) begin
      done_ch   = cur_ch;
      done_duty = duty_calc;
    end
  end

endmodule

// File: tb/tb_pwm_capture_scheduler.sv
// Directed bench for pwm_capture_scheduler with PERIOD=100 and four channels.
// Stimulus waveforms are period-aligned so every 100-cycle window has an exact high count.
// Expected duties and timings are hand-derived constants.
module tb_pwm_capture_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] signals = '0;
    logic       pri_req;
    logic [1:0] pri_ch;
    logic [1:0] rd_sel;
    logic [9:0] rd_duty;
    logic       done;
    logic [1:0] done_ch;
    logic [9:0] done_duty;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int ph = 0;
    logic tog = 1'b0;
    logic ch0_toggle = 1'b0;

    pwm_capture_scheduler #(
        .NUM_CH(4),
        .PERIOD_WIDTH_NS(1000),
        .SYS_FREQ_MHZ(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .signals(signals),
        .pri_req(pri_req),
        .pri_ch(pri_ch),
        .rd_sel(rd_sel),
        .rd_duty(rd_duty),
        .done(done),
        .done_ch(done_ch),
        .done_duty(done_duty),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // PWM source: ch0 high (or toggling), ch1 25/100, ch2 low, ch3 50/100.
    always @(negedge clk) begin
        ph  = (ph == 99) ? 0 : ph + 1;
        tog = ~tog;
        signals[0] = ch0_toggle ? tog : 1'b1;
        signals[1] = (ph < 25);
        signals[2] = 1'b0;
        signals[3] = (ph < 50);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_done(input int lim, output bit got, output int ch,
                             output int dt, output int n);
        got = 0; ch = -1; dt = -1; n = 0;
        while (!got && n < lim) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                got = 1;
                ch  = int'(done_ch);
                dt  = int'(done_duty);
            end
        end
    endtask

    initial begin
        bit got;
        int ch, dt, n;
        int exp_duty [4];
        int last [4];
        exp_duty[0] = 1023; exp_duty[1] = 255; exp_duty[2] = 0; exp_duty[3] = 511;
        for (int i = 0; i < 4; i++) last[i] = -1;

        reset = 1'b1; enable = 1'b0; pri_req = 1'b0; pri_ch = 2'd0; rd_sel = 2'd0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_done_ch", done_ch, 0);
        chk("reset_done_duty", done_duty, 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i); #1;
            chk("reset_rd_duty", rd_duty, 0);
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;

        // Basic scan and three full rotations at 101-cycle spacing.
        for (int i = 0; i < 12; i++) begin
            wait_done(200, got, ch, dt, n);
            chk("scan_got", got, 1);
            chk("scan_ch", ch, i % 4);
            chk("scan_duty", dt, exp_duty[i % 4]);
            chk("scan_spacing", n, 101);
            if (ch >= 0 && ch < 4) last[ch] = dt;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i); #1;
            chk("rd_matches_last", rd_duty, last[i]);
        end

        // Priority: request ch2 across the store of ch0, hold it once more, then release.
        pri_req = 1'b1; pri_ch = 2'd2;
        wait_done(200, got, ch, dt, n);
        chk("pri_first_ch", ch, 0);
        wait_done(200, got, ch, dt, n);
        chk("pri_jump_ch", ch, 2);
        chk("pri_jump_duty", dt, 0);
        chk("pri_jump_spacing", n, 101);
        wait_done(200, got, ch, dt, n);
        chk("pri_repeat_ch", ch, 2);
        pri_req = 1'b0;
        wait_done(200, got, ch, dt, n);
        chk("pri_resume_ch", ch, 3);
        chk("pri_resume_duty", dt, 511);
        wait_done(200, got, ch, dt, n);
        chk("pri_wrap_ch", ch, 0);

        // Disable at cnt=50 of ch1: measurement discarded, same channel on re-enable.
        repeat (51) @(negedge clk);
        enable = 1'b0; #1;
        chk("dis_busy_before", busy, 1);
        @(negedge clk); @(negedge clk);
        chk("dis_busy_after", busy, 0);
        wait_done(150, got, ch, dt, n);
        chk("dis_no_done", got, 0);
        rd_sel = 2'd1; #1;
        chk("dis_duty1_kept", rd_duty, 255);
        @(negedge clk);
        enable = 1'b1;
        wait_done(200, got, ch, dt, n);
        chk("reen_got", got, 1);
        chk("reen_ch", ch, 1);
        chk("reen_duty", dt, 255);
        chk("reen_latency", n, 101);

        // Asynchronous reset in the middle of the ch2 measurement.
        repeat (30) @(negedge clk);
        #3 reset = 1'b1; enable = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i); #1;
            chk("arst_rd_duty", rd_duty, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_done(200, got, ch, dt, n);
        chk("post_rst_ch", ch, 0);
        chk("post_rst_duty", dt, 1023);
        chk("post_rst_latency", n, 101);

        // Every-cycle toggling on ch0; read-during-store returns the old value.
        ch0_toggle = 1'b1;
        for (int i = 1; i < 4; i++) begin
            wait_done(200, got, ch, dt, n);
            chk("tog_rot_ch", ch, i);
            chk("tog_rot_duty", dt, exp_duty[i]);
        end
        wait_done(200, got, ch, dt, n);
        chk("tog_ch", ch, 0);
        chk("tog_duty_range", (dt >= 501 && dt <= 521), 1);
        chk("tog_no_x", $isunknown(done_duty), 0);
        rd_sel = 2'd0; #1;
        chk("rd_during_store_old", rd_duty, 1023);
        @(negedge clk); #1;
        chk("rd_after_store_new", rd_duty, dt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
